// File: rtl/mdu_iter_if.sv
// rtl/mdu_iter_if.sv - request/response bundle between the execute stage and mdu_iter
interface mdu_iter_if #(
   parameter int WIDTH = 32
) ();
   logic                 flush_i;
   logic                 start_i;
   logic [2:0]           op_i;
   logic [WIDTH-1:0]     a_i;
   logic [WIDTH-1:0]     b_i;
   logic [2*WIDTH-1:0]   hilo_i;
   logic                 busy_o;
   logic                 done_o;
   logic [2*WIDTH-1:0]   result_o;
   logic                 div_zero_o;

   modport master (
      output flush_i, start_i, op_i, a_i, b_i, hilo_i,
      input  busy_o, done_o, result_o, div_zero_o
   );

   modport slave (
      input  flush_i, start_i, op_i, a_i, b_i, hilo_i,
      output busy_o, done_o, result_o, div_zero_o
   );
endinterface

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative one-bit-per-cycle multiply/divide/accumulate unit
module mdu_iter #(
   parameter int WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst,
   mdu_iter_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam int W2 = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q;
   logic [2:0]        op_q;
   logic [WIDTH-1:0]  a_raw_q;
   logic [WIDTH-1:0]  d_q;
   logic [WIDTH-1:0]  hi_q, lo_q;
   logic [WIDTH-1:0]  hi_d, lo_d;
   logic [W2-1:0]     hilo_q;
   logic              neg_res_q, neg_rem_q, bzero_q;
   logic [W2-1:0]     result_q;
   logic              div_zero_q;

   logic              accept;
   logic              in_div, in_signed, a_neg, b_neg;
   logic [WIDTH-1:0]  a_mag, b_mag;
   logic              op_div;
   logic [WIDTH:0]    mul_sum, div_rem, div_diff;
   logic [W2-1:0]     prod, sprod, fix_result;
   logic [WIDTH-1:0]  quo_fix, rem_fix;

   assign accept    = bus.start_i & ~bus.flush_i & ((state_q == IDLE) | (state_q == DONE));
   assign in_div    = (bus.op_i[2:1] == 2'b01);
   assign in_signed = ~bus.op_i[0];
   assign a_neg     = in_signed & bus.a_i[WIDTH-1];
   assign b_neg     = in_signed & bus.b_i[WIDTH-1];
   assign a_mag     = a_neg ? -bus.a_i : bus.a_i;
   assign b_mag     = b_neg ? -bus.b_i : bus.b_i;
   assign op_div    = (op_q[2:1] == 2'b01);

   // hi/lo hold {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
   always_comb begin
      mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, d_q} : '0);
      div_rem  = {hi_q, lo_q[WIDTH-1]};
      div_diff = div_rem - {1'b0, d_q};
      if (op_div) begin
         hi_d = div_diff[WIDTH] ? div_rem[WIDTH-1:0] : div_diff[WIDTH-1:0];
         lo_d = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
      end else begin
         hi_d = mul_sum[WIDTH:1];
         lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
   end

   always_comb begin
      prod    = {hi_q, lo_q};
      sprod   = neg_res_q ? -prod : prod;
      quo_fix = neg_res_q ? -lo_q : lo_q;
      rem_fix = neg_rem_q ? -hi_q : hi_q;
      case (op_q)
         3'd0, 3'd1: fix_result = sprod;
         3'd2, 3'd3: fix_result = bzero_q ? {a_raw_q, {WIDTH{1'b1}}} : {rem_fix, quo_fix};
         3'd4, 3'd5: fix_result = hilo_q + sprod;
         default:    fix_result = hilo_q - sprod;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.flush_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            FIX:     state_d = DONE;
            default: state_d = accept ? CALC : IDLE;
         endcase
      end
   end

   always_comb begin
      bus.busy_o = (state_q == CALC) | (state_q == FIX);
      bus.done_o = (state_q == DONE);
   end

   assign bus.result_o   = result_q;
   assign bus.div_zero_o = div_zero_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         op_q       <= '0;
         a_raw_q    <= '0;
         d_q        <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         hilo_q     <= '0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         bzero_q    <= 1'b0;
         result_q   <= '0;
         div_zero_q <= 1'b0;
      end else begin
         if (accept) begin
            cnt_q     <= '0;
            op_q      <= bus.op_i;
            a_raw_q   <= bus.a_i;
            hilo_q    <= bus.hilo_i;
            d_q       <= in_div ? b_mag : a_mag;
            lo_q      <= in_div ? a_mag : b_mag;
            hi_q      <= '0;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            bzero_q   <= (bus.b_i == '0);
         end else if (state_q == CALC) begin
            cnt_q <= cnt_q + CW'(1);
            hi_q  <= hi_d;
            lo_q  <= lo_d;
         end
         // an aborted FIX leaves the previously committed result visible
         if ((state_q == FIX) && !bus.flush_i) begin
            result_q   <= fix_result;
            div_zero_q <= op_div & bzero_q;
         end
      end
   end
endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - randomized and directed self-checking bench for mdu_iter
module tb_mdu_iter;
   localparam int W = 32;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   logic [63:0] last_res;

   mdu_iter_if #(.WIDTH(W)) bus ();

   mdu_iter #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // arithmetic reference: {div_zero, {HI, LO}}
   function automatic logic [64:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] hilo);
      logic signed [63:0] sa64, sb64, sp;
      logic [63:0]        up;
      int                 sa, sb;
      logic [31:0]        q, r;
      sa64 = $signed(a);
      sb64 = $signed(b);
      sp   = sa64 * sb64;
      up   = {32'd0, a} * {32'd0, b};
      sa   = a;
      sb   = b;
      case (op)
         3'd0: return {1'b0, sp};
         3'd1: return {1'b0, up};
         3'd2: begin
            if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
            q = sa / sb;
            r = sa % sb;
            return {1'b0, r, q};
         end
         3'd3: begin
            if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
            q = a / b;
            r = a % b;
            return {1'b0, r, q};
         end
         3'd4: return {1'b0, hilo + sp};
         3'd5: return {1'b0, hilo + up};
         3'd6: return {1'b0, hilo - sp};
         default: return {1'b0, hilo - up};
      endcase
   endfunction

   // drive a request at a negedge; returns at the negedge of cycle 1 with operands scrambled
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] hilo);
      bus.start_i = 1'b1;
      bus.op_i    = op;
      bus.a_i     = a;
      bus.b_i     = b;
      bus.hilo_i  = hilo;
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.op_i    = 3'($urandom);
      bus.a_i     = $urandom;
      bus.b_i     = $urandom;
      bus.hilo_i  = {$urandom, $urandom};
   endtask

   task automatic wait_done(input int cyc0, output int cyc, output int busy_err);
      cyc      = cyc0;
      busy_err = 0;
      while (!bus.done_o && cyc < 200) begin
         if (!bus.busy_o) busy_err++;
         @(negedge clk);
         cyc++;
      end
      if (bus.busy_o) busy_err++;
   endtask

   task automatic count_done(input int n, output int pulses);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (bus.done_o) pulses++;
      end
   endtask

   task automatic run_check(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [63:0] hilo,
                            input logic [63:0] exp_res, input logic exp_dz);
      int cyc, berr;
      issue(op, a, b, hilo);
      wait_done(1, cyc, berr);
      check({tag, ".done_cycle"}, 64'(cyc), 64'(W + 2));
      check({tag, ".busy"}, 64'(berr), 64'd0);
      check({tag, ".result"}, bus.result_o, exp_res);
      check({tag, ".div_zero"}, {63'd0, bus.div_zero_o}, {63'd0, exp_dz});
      last_res = exp_res;
   endtask

   initial begin
      logic [64:0] m;
      logic [2:0]  op;
      logic [31:0] a, b;
      logic [63:0] hilo;
      int          cyc, berr, pulses, sel;

      n_tests     = 0;
      n_fail      = 0;
      last_res    = '0;
      rst         = 1'b1;
      bus.flush_i = 1'b0;
      bus.start_i = 1'b0;
      bus.op_i    = '0;
      bus.a_i     = '0;
      bus.b_i     = '0;
      bus.hilo_i  = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset.busy", {63'd0, bus.busy_o}, 64'd0);
      check("reset.done", {63'd0, bus.done_o}, 64'd0);
      check("reset.result", bus.result_o, 64'd0);
      check("reset.div_zero", {63'd0, bus.div_zero_o}, 64'd0);

      run_check("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
      run_check("divu", 3'd3, 32'd100, 32'd7, 64'd0, {32'd2, 32'd14}, 1'b0);
      run_check("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 64'd0, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
      run_check("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, {32'd0, 32'h8000_0000}, 1'b0);
      run_check("div_zero", 3'd2, 32'h1234_5678, 32'd0, 64'd0, {32'h1234_5678, 32'hFFFF_FFFF}, 1'b1);
      run_check("divu_zero", 3'd3, 32'hDEAD_BEEF, 32'd0, 64'd0, {32'hDEAD_BEEF, 32'hFFFF_FFFF}, 1'b1);
      run_check("msub", 3'd6, 32'd3, 32'hFFFF_FFFE, 64'h10, 64'h16, 1'b0);
      run_check("maddu_wrap", 3'd5, 32'd1, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);

      // back-to-back: second request issued in the DONE cycle of the first
      run_check("b2b_first", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFE_0000_0001, 1'b0);
      run_check("b2b_second", 3'd3, 32'd1000, 32'd10, 64'd0, {32'd0, 32'd100}, 1'b0);

      repeat (2) @(negedge clk);
      for (int t = 0; t < 60; t++) begin
         op   = 3'($urandom_range(0, 7));
         a    = $urandom;
         b    = $urandom;
         hilo = {$urandom, $urandom};
         sel  = $urandom_range(0, 7);
         if (sel == 0) b = 32'd0;
         if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         if (sel == 2) begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
         if (sel == 3) b = -32'($urandom_range(1, 20));
         m = ref_mdu(op, a, b, hilo);
         run_check($sformatf("rand%0d_op%0d", t, op), op, a, b, hilo, m[63:0], m[64]);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // flush mid-CALC: no pulse, result untouched
      issue(3'd1, 32'h1357_9BDF, 32'h2468_ACE0, 64'd0);
      repeat (9) @(negedge clk);
      bus.flush_i = 1'b1;
      @(negedge clk);
      bus.flush_i = 1'b0;
      check("flush.busy", {63'd0, bus.busy_o}, 64'd0);
      count_done(W + 6, pulses);
      check("flush.no_done", 64'(pulses), 64'd0);
      check("flush.result", bus.result_o, last_res);

      // flush together with start in IDLE
      bus.start_i = 1'b1;
      bus.flush_i = 1'b1;
      bus.op_i    = 3'd1;
      bus.a_i     = 32'd7;
      bus.b_i     = 32'd9;
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.flush_i = 1'b0;
      check("flush_start.busy", {63'd0, bus.busy_o}, 64'd0);
      count_done(W + 6, pulses);
      check("flush_start.no_done", 64'(pulses), 64'd0);

      // start during CALC is ignored
      issue(3'd1, 32'd11, 32'd13, 64'd0);
      repeat (4) @(negedge clk);
      bus.start_i = 1'b1;
      bus.op_i    = 3'd1;
      bus.a_i     = 32'd2;
      bus.b_i     = 32'd3;
      @(negedge clk);
      bus.start_i = 1'b0;
      wait_done(6, cyc, berr);
      check("ignored_start.done_cycle", 64'(cyc), 64'(W + 2));
      check("ignored_start.result", bus.result_o, 64'd143);
      count_done(W + 6, pulses);
      check("ignored_start.no_extra_done", 64'(pulses), 64'd0);

      // reset mid-CALC clears everything
      issue(3'd0, 32'hFFFF_FFFF, 32'd77, 64'd0);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst.busy", {63'd0, bus.busy_o}, 64'd0);
      check("midrst.done", {63'd0, bus.done_o}, 64'd0);
      check("midrst.result", bus.result_o, 64'd0);
      check("midrst.div_zero", {63'd0, bus.div_zero_o}, 64'd0);
      count_done(W + 6, pulses);
      check("midrst.no_done", 64'(pulses), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
